// File: rtl/cavlc_pkg.sv
// Shared constants and packer state encoding for the CAVLC total_zeros encoder.
package cavlc_pkg;
    localparam int WORD_W     = 16;
    localparam int MAX_TZ_LEN = 9;
    localparam int ACC_W      = WORD_W + MAX_TZ_LEN - 1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } pack_state_t;
endpackage

// File: rtl/total_zeros_vlc_lut.sv
// Combinational total_zeros codeword lookup: 4x4 luma tables and the 2x2 chroma DC table.
module total_zeros_vlc_lut
    import cavlc_pkg::*;
(
    input  logic [3:0]            TotalCoeff,
    input  logic [3:0]            total_zeros,
    input  logic                  chroma_dc,
    output logic [MAX_TZ_LEN-1:0] code,
    output logic [3:0]            len,
    output logic                  illegal
);
    logic [12:0] entry;

    function automatic logic [12:0] cw(input logic [3:0] l, input logic [8:0] c);
        return {l, c};
    endfunction

    // Key is {chroma_dc, TotalCoeff, total_zeros}; anything not listed has no codeword.
    always_comb begin
        entry = '0;
        case ({chroma_dc, TotalCoeff, total_zeros})
            9'h010: entry = cw(4'd1, 9'b1);         9'h011: entry = cw(4'd3, 9'b011);       9'h012: entry = cw(4'd3, 9'b010);       9'h013: entry = cw(4'd4, 9'b0011);
            9'h014: entry = cw(4'd4, 9'b0010);      9'h015: entry = cw(4'd5, 9'b00011);     9'h016: entry = cw(4'd5, 9'b00010);     9'h017: entry = cw(4'd6, 9'b000011);
            9'h018: entry = cw(4'd6, 9'b000010);    9'h019: entry = cw(4'd7, 9'b0000011);   9'h01A: entry = cw(4'd7, 9'b0000010);   9'h01B: entry = cw(4'd8, 9'b00000011);
            9'h01C: entry = cw(4'd8, 9'b00000010);  9'h01D: entry = cw(4'd9, 9'b000000011); 9'h01E: entry = cw(4'd9, 9'b000000010); 9'h01F: entry = cw(4'd9, 9'b000000001);
            9'h020: entry = cw(4'd3, 9'b111);       9'h021: entry = cw(4'd3, 9'b110);       9'h022: entry = cw(4'd3, 9'b101);       9'h023: entry = cw(4'd3, 9'b100);
            9'h024: entry = cw(4'd3, 9'b011);       9'h025: entry = cw(4'd4, 9'b0101);      9'h026: entry = cw(4'd4, 9'b0100);      9'h027: entry = cw(4'd4, 9'b0011);
            9'h028: entry = cw(4'd4, 9'b0010);      9'h029: entry = cw(4'd5, 9'b00011);     9'h02A: entry = cw(4'd5, 9'b00010);     9'h02B: entry = cw(4'd6, 9'b000011);
            9'h02C: entry = cw(4'd6, 9'b000010);    9'h02D: entry = cw(4'd6, 9'b000001);    9'h02E: entry = cw(4'd6, 9'b000000);
            9'h030: entry = cw(4'd4, 9'b0101);      9'h031: entry = cw(4'd3, 9'b111);       9'h032: entry = cw(4'd3, 9'b110);       9'h033: entry = cw(4'd3, 9'b101);
            9'h034: entry = cw(4'd4, 9'b0100);      9'h035: entry = cw(4'd4, 9'b0011);      9'h036: entry = cw(4'd3, 9'b100);       9'h037: entry = cw(4'd3, 9'b011);
            9'h038: entry = cw(4'd4, 9'b0010);      9'h039: entry = cw(4'd5, 9'b00011);     9'h03A: entry = cw(4'd5, 9'b00010);     9'h03B: entry = cw(4'd6, 9'b000001);
            9'h03C: entry = cw(4'd5, 9'b00001);     9'h03D: entry = cw(4'd6, 9'b000000);
            9'h040: entry = cw(4'd5, 9'b00011);     9'h041: entry = cw(4'd3, 9'b111);       9'h042: entry = cw(4'd4, 9'b0101);      9'h043: entry = cw(4'd4, 9'b0100);
            9'h044: entry = cw(4'd3, 9'b110);       9'h045: entry = cw(4'd3, 9'b101);       9'h046: entry = cw(4'd3, 9'b100);       9'h047: entry = cw(4'd4, 9'b0011);
            9'h048: entry = cw(4'd3, 9'b011);       9'h049: entry = cw(4'd4, 9'b0010);      9'h04A: entry = cw(4'd5, 9'b00010);     9'h04B: entry = cw(4'd5, 9'b00001);
            9'h04C: entry = cw(4'd5, 9'b00000);
            9'h050: entry = cw(4'd4, 9'b0101);      9'h051: entry = cw(4'd4, 9'b0100);      9'h052: entry = cw(4'd4, 9'b0011);      9'h053: entry = cw(4'd3, 9'b111);
            9'h054: entry = cw(4'd3, 9'b110);       9'h055: entry = cw(4'd3, 9'b101);       9'h056: entry = cw(4'd3, 9'b100);       9'h057: entry = cw(4'd3, 9'b011);
            9'h058: entry = cw(4'd4, 9'b0010);      9'h059: entry = cw(4'd5, 9'b00001);     9'h05A: entry = cw(4'd4, 9'b0001);      9'h05B: entry = cw(4'd5, 9'b00000);
            9'h060: entry = cw(4'd6, 9'b000001);    9'h061: entry = cw(4'd5, 9'b00001);     9'h062: entry = cw(4'd3, 9'b111);       9'h063: entry = cw(4'd3, 9'b110);
            9'h064: entry = cw(4'd3, 9'b101);       9'h065: entry = cw(4'd3, 9'b100);       9'h066: entry = cw(4'd3, 9'b011);       9'h067: entry = cw(4'd3, 9'b010);
            9'h068: entry = cw(4'd4, 9'b0001);      9'h069: entry = cw(4'd3, 9'b001);       9'h06A: entry = cw(4'd6, 9'b000000);
            9'h070: entry = cw(4'd6, 9'b000001);    9'h071: entry = cw(4'd5, 9'b00001);     9'h072: entry = cw(4'd3, 9'b101);       9'h073: entry = cw(4'd3, 9'b100);
            9'h074: entry = cw(4'd3, 9'b011);       9'h075: entry = cw(4'd2, 9'b11);        9'h076: entry = cw(4'd3, 9'b010);       9'h077: entry = cw(4'd4, 9'b0001);
            9'h078: entry = cw(4'd3, 9'b001);       9'h079: entry = cw(4'd6, 9'b000000);
            9'h080: entry = cw(4'd6, 9'b000001);    9'h081: entry = cw(4'd4, 9'b0001);      9'h082: entry = cw(4'd5, 9'b00001);     9'h083: entry = cw(4'd3, 9'b011);
            9'h084: entry = cw(4'd2, 9'b11);        9'h085: entry = cw(4'd2, 9'b10);        9'h086: entry = cw(4'd3, 9'b010);       9'h087: entry = cw(4'd3, 9'b001);
            9'h088: entry = cw(4'd6, 9'b000000);
            9'h090: entry = cw(4'd6, 9'b000001);    9'h091: entry = cw(4'd6, 9'b000000);    9'h092: entry = cw(4'd4, 9'b0001);      9'h093: entry = cw(4'd2, 9'b11);
            9'h094: entry = cw(4'd2, 9'b10);        9'h095: entry = cw(4'd3, 9'b001);       9'h096: entry = cw(4'd2, 9'b01);        9'h097: entry = cw(4'd5, 9'b00001);
            9'h0A0: entry = cw(4'd5, 9'b00001);     9'h0A1: entry = cw(4'd5, 9'b00000);     9'h0A2: entry = cw(4'd3, 9'b001);       9'h0A3: entry = cw(4'd2, 9'b11);
            9'h0A4: entry = cw(4'd2, 9'b10);        9'h0A5: entry = cw(4'd2, 9'b01);        9'h0A6: entry = cw(4'd4, 9'b0001);
            9'h0B0: entry = cw(4'd4, 9'b0000);      9'h0B1: entry = cw(4'd4, 9'b0001);      9'h0B2: entry = cw(4'd3, 9'b001);       9'h0B3: entry = cw(4'd3, 9'b010);
            9'h0B4: entry = cw(4'd1, 9'b1);         9'h0B5: entry = cw(4'd3, 9'b011);
            9'h0C0: entry = cw(4'd4, 9'b0000);      9'h0C1: entry = cw(4'd4, 9'b0001);      9'h0C2: entry = cw(4'd2, 9'b01);        9'h0C3: entry = cw(4'd1, 9'b1);
            9'h0C4: entry = cw(4'd3, 9'b001);
            9'h0D0: entry = cw(4'd3, 9'b000);       9'h0D1: entry = cw(4'd3, 9'b001);       9'h0D2: entry = cw(4'd1, 9'b1);         9'h0D3: entry = cw(4'd2, 9'b01);
            9'h0E0: entry = cw(4'd2, 9'b00);        9'h0E1: entry = cw(4'd2, 9'b01);        9'h0E2: entry = cw(4'd1, 9'b1);
            9'h0F0: entry = cw(4'd1, 9'b0);         9'h0F1: entry = cw(4'd1, 9'b1);
            9'h110: entry = cw(4'd1, 9'b1);         9'h111: entry = cw(4'd2, 9'b01);        9'h112: entry = cw(4'd3, 9'b001);       9'h113: entry = cw(4'd3, 9'b000);
            9'h120: entry = cw(4'd1, 9'b1);         9'h121: entry = cw(4'd2, 9'b01);        9'h122: entry = cw(4'd2, 9'b00);
            9'h130: entry = cw(4'd1, 9'b1);         9'h131: entry = cw(4'd1, 9'b0);
            default: entry = '0;
        endcase
    end

    assign len  = entry[12:9];
    assign code = entry[8:0];

    assign illegal = chroma_dc
        ? ((TotalCoeff > 4'd3) || ({1'b0, total_zeros} > (5'd4 - {1'b0, TotalCoeff})))
        : ({1'b0, total_zeros} > (5'd16 - {1'b0, TotalCoeff}));
endmodule

// File: rtl/total_zeros_encoding.sv
// CAVLC total_zeros encoder: LUT register stage feeding an MSB-first 16-bit word packer.
// state | meaning
// ACCUM | normal merging of stage 1 into the accumulator
// HOLD  | word register full; merges allowed only if they do not complete another word
// FLUSH | drain stage 1 and the word register, then emit any partial word
module total_zeros_encoding
    import cavlc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tz_valid,
    output logic              tz_ready,
    input  logic [3:0]        TotalCoeff,
    input  logic [3:0]        total_zeros,
    input  logic              chroma_dc,
    input  logic              flush,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word,
    output logic [4:0]        word_bits,
    output logic              err
);
    logic [MAX_TZ_LEN-1:0] lut_code;
    logic [3:0]            lut_len;
    logic                  lut_illegal;

    logic                  s1_valid;
    logic [MAX_TZ_LEN-1:0] s1_code;
    logic [3:0]            s1_len;
    logic [ACC_W-1:0]      acc;
    logic [4:0]            fill;
    pack_state_t           state, state_next;

    logic                  accept, merge, completes, wreg_free, flush_emit, load_word;
    logic [4:0]            fill_sum;
    logic [ACC_W-1:0]      merged;

    total_zeros_vlc_lut u_lut (
        .TotalCoeff  (TotalCoeff),
        .total_zeros (total_zeros),
        .chroma_dc   (chroma_dc),
        .code        (lut_code),
        .len         (lut_len),
        .illegal     (lut_illegal)
    );

    // Left-align the codeword at the top of the accumulator, then slide it down past the pending bits.
    assign wreg_free = !word_valid || word_ready;
    assign fill_sum  = fill + {1'b0, s1_len};
    assign completes = fill_sum >= 5'd16;
    assign merged    = acc | (({s1_code, {(ACC_W - MAX_TZ_LEN){1'b0}}} << (4'd9 - s1_len)) >> fill);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (flush) state_next = FLUSH;
                   else if (load_word) state_next = HOLD;
            HOLD:  if (flush) state_next = FLUSH;
                   else if (word_valid && word_ready && !load_word) state_next = ACCUM;
            FLUSH: if (!s1_valid && wreg_free) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        merge      = s1_valid && (!completes || wreg_free);
        flush_emit = (state == FLUSH) && !s1_valid && wreg_free && (fill != 5'd0);
        tz_ready   = (state != FLUSH) && (!s1_valid || merge);
        accept     = tz_valid && tz_ready;
        load_word  = (merge && completes) || flush_emit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_code    <= '0;
            s1_len     <= '0;
            acc        <= '0;
            fill       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
            word_bits  <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_code  <= lut_code;
                s1_len   <= lut_len;
            end else if (merge) begin
                s1_valid <= 1'b0;
            end

            if (merge && completes) begin
                acc  <= merged << WORD_W;
                fill <= fill_sum - 5'd16;
            end else if (merge) begin
                acc  <= merged;
                fill <= fill_sum;
            end else if (flush_emit) begin
                acc  <= '0;
                fill <= '0;
            end

            if (merge && completes) begin
                word       <= merged[ACC_W-1 -: WORD_W];
                word_bits  <= 5'd16;
                word_valid <= 1'b1;
            end else if (flush_emit) begin
                word       <= acc[ACC_W-1 -: WORD_W];
                word_bits  <= fill;
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end

            if (accept && lut_illegal) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_total_zeros_encoding.sv
// Directed self-checking bench for total_zeros_encoding with hand-computed expected words.
module tb_total_zeros_encoding;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tz_valid = 1'b0;
    logic        tz_ready;
    logic [3:0]  TotalCoeff = '0;
    logic [3:0]  total_zeros = '0;
    logic        chroma_dc = 1'b0;
    logic        flush = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [15:0] word;
    logic [4:0]  word_bits;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [20:0] got [$];

    total_zeros_encoding dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tz_valid    (tz_valid),
        .tz_ready    (tz_ready),
        .TotalCoeff  (TotalCoeff),
        .total_zeros (total_zeros),
        .chroma_dc   (chroma_dc),
        .flush       (flush),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word        (word),
        .word_bits   (word_bits),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Transfers are seen half a cycle ahead of the edge that completes them.
    always @(negedge clk)
        if (reset_n && word_valid && word_ready) got.push_back({word_bits, word});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    function automatic logic [20:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 21'h1FFFFF;
    endfunction

    // Stream of repeated "000000001": a bit is set where its stream position is 8 mod 9.
    function automatic logic [15:0] stream_word(input int k, input int nbits);
        logic [15:0] w = '0;
        for (int j = 0; j < 16; j++)
            if (j < nbits && ((16 * k + j) % 9 == 8)) w[15 - j] = 1'b1;
        return w;
    endfunction

    task automatic hold_reset();
        reset_n = 1'b0;
        tz_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [3:0] tc, input logic [3:0] tz, input logic cd, input logic fl);
        int n = 0;
        TotalCoeff = tc;
        total_zeros = tz;
        chroma_dc = cd;
        flush = fl;
        tz_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!tz_ready && n < 200);
        if (!tz_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tz_ready=%b after %0d cycles, required 1", tz_ready, n);
        end
        @(posedge clk);
        #1;
        tz_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (got.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (tz_ready !== 1'b1) begin errors++; $display("FAIL reset_tz_ready: got %b required 1", tz_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b required 0", word_valid); end
        checks++; if (word !== 16'h0000) begin errors++; $display("FAIL reset_word: got %h required 0000", word); end
        checks++; if (word_bits !== 5'd0) begin errors++; $display("FAIL reset_word_bits: got %0d required 0", word_bits); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        reset_n = 1'b1;
    endtask

    task automatic test_full_word();
        int t0;
        got.delete();
        word_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_pair(4'd1, 4'd0, 1'b0, 1'b0);
        checks++; if (cyc - t0 !== 16) begin errors++; $display("FAIL full_throughput: got %0d cycles required 16", cyc - t0); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b required 0", word_valid); end
        @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b required 1", word_valid); end
        checks++; if (word !== 16'hFFFF || word_bits !== 5'd16) begin errors++; $display("FAIL full_word: got %h/%0d required ffff/16", word, word_bits); end
        do_flush();
        repeat (6) @(posedge clk);
        #1;
        checks++; if (got.size() !== 1 || got_at(0) !== {5'd16, 16'hFFFF}) begin errors++; $display("FAIL full_count: got %0d words first %h required 1 word 10ffff", got.size(), got_at(0)); end
    endtask

    task automatic test_mixed_flush();
        got.delete();
        send_pair(4'd1, 4'd15, 1'b0, 1'b0);
        send_pair(4'd2, 4'd0, 1'b0, 1'b0);
        send_pair(4'd3, 4'd1, 1'b0, 1'b0);
        do_flush();
        wait_words(1);
        checks++; if (got_at(0) !== {5'd15, 16'h00FE}) begin errors++; $display("FAIL mixed_word: got %h required %h", got_at(0), {5'd15, 16'h00FE}); end
    endtask

    task automatic test_chroma_dc();
        got.delete();
        send_pair(4'd1, 4'd2, 1'b1, 1'b0);
        send_pair(4'd2, 4'd1, 1'b1, 1'b1);
        wait_words(1);
        checks++; if (got_at(0) !== {5'd5, 16'h2800}) begin errors++; $display("FAIL chroma_word: got %h required %h", got_at(0), {5'd5, 16'h2800}); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL chroma_count: got %0d required 1", got.size()); end
    endtask

    task automatic test_table_rows();
        got.delete();
        send_pair(4'd5, 4'd3, 1'b0, 1'b0);
        send_pair(4'd9, 4'd6, 1'b0, 1'b0);
        send_pair(4'd0, 4'd0, 1'b0, 1'b0);
        send_pair(4'd11, 4'd4, 1'b0, 1'b0);
        send_pair(4'd6, 4'd0, 1'b0, 1'b0);
        send_pair(4'd13, 4'd3, 1'b0, 1'b1);
        wait_words(1);
        checks++; if (got_at(0) !== {5'd14, 16'hEC14}) begin errors++; $display("FAIL table_word: got %h required %h", got_at(0), {5'd14, 16'hEC14}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL table_err: got %b required 0", err); end
    endtask

    task automatic test_illegal();
        got.delete();
        send_pair(4'd14, 4'd3, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b required 1", err); end
        send_pair(4'd15, 4'd1, 1'b0, 1'b0);
        do_flush();
        wait_words(1);
        checks++; if (got_at(0) !== {5'd1, 16'h8000}) begin errors++; $display("FAIL illegal_word: got %h required %h", got_at(0), {5'd1, 16'h8000}); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b required 1", err); end
        hold_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_reset_err: got %b required 0", err); end
        reset_n = 1'b1;
    endtask

    task automatic test_backpressure();
        got.delete();
        word_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_pair(4'd1, 4'd15, 1'b0, 1'b0);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                word_ready = 1'b1;
            end
            begin
                int c = 0;
                logic [15:0] held;
                while (!word_valid && c < 50) begin @(negedge clk); c++; end
                held = word;
                c = 0;
                while (tz_ready && c < 10) begin @(negedge clk); c++; end
                checks++; if (tz_ready !== 1'b0 || c > 3) begin errors++; $display("FAIL bp_stall: tz_ready=%b after %0d cycles, required 0 within 3", tz_ready, c); end
                @(negedge clk);
                checks++; if (word_valid !== 1'b1 || word !== held || held !== 16'h0080) begin errors++; $display("FAIL bp_hold: got %b/%h required 1/0080 held", word_valid, word); end
            end
        join
        do_flush();
        wait_words(23);
        checks++; if (got.size() !== 23) begin errors++; $display("FAIL bp_count: got %0d words required 23", got.size()); end
        for (int k = 0; k < 23; k++) begin
            logic [20:0] exp_w;
            exp_w = (k < 22) ? {5'd16, stream_word(k, 16)} : {5'd8, stream_word(k, 8)};
            checks++;
            if (got_at(k) !== exp_w) begin errors++; $display("FAIL bp_word_%0d: got %h required %h", k, got_at(k), exp_w); end
        end
    endtask

    task automatic test_reset_mid();
        got.delete();
        word_ready = 1'b0;
        for (int i = 0; i < 23; i++) send_pair(4'd1, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b1 || word !== 16'hFFFF) begin errors++; $display("FAIL mid_pre_reset: got %b/%h required 1/ffff", word_valid, word); end
        hold_reset();
        checks++; if (tz_ready !== 1'b1) begin errors++; $display("FAIL mid_tz_ready: got %b required 1", tz_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL mid_word_valid: got %b required 0", word_valid); end
        checks++; if (word !== 16'h0000 || word_bits !== 5'd0) begin errors++; $display("FAIL mid_word: got %h/%0d required 0000/0", word, word_bits); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b required 0", err); end
        reset_n = 1'b1;
        got.delete();
        word_ready = 1'b1;
        send_pair(4'd1, 4'd0, 1'b0, 1'b0);
        do_flush();
        wait_words(1);
        checks++; if (got_at(0) !== {5'd1, 16'h8000} || got.size() !== 1) begin errors++; $display("FAIL mid_after_word: got %h (%0d words) required %h", got_at(0), got.size(), {5'd1, 16'h8000}); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_mixed_flush();
        test_chroma_dc();
        test_table_rows();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
